// File: rtl/shared_data_writer_if.sv
// AXI4-lite bus bundle. The master modport carries both read and write
// channels so a write-only master still presents a complete bus.
interface axi4_lite_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            awvalid;
   logic            awready;
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic            arvalid;
   logic            arready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            rvalid;
   logic            rready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;

   modport m (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport s (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/shared_data_writer.sv
// Packs a received byte stream little-endian into 32-bit words and writes
// each word to a shared memory region over AXI4-lite, one word at a time.
module shared_data_writer #(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned DEPTH_WORDS = 512
) (
   input  logic       clk,
   input  logic       aresetn,
   input  logic       db_valid,
   input  logic [7:0] db_data,
   input  logic       db_sof,
   input  logic       db_eof,
   output logic       db_ready,
   axi4_lite_if.m     m_axi,
   output logic       frame_done,
   output logic       err_overflow,
   output logic       err_resp,
   output logic       busy
);

   // index must be able to hold DEPTH_WORDS itself (the "region full" value)
   localparam int IW = $clog2(DEPTH_WORDS + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RESP} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [2:0]    lane_q, lane_d;      // lanes filled in the current word (0..4)
   logic [31:0]   data_q, data_d;
   logic          last_q, last_d;      // current word closes the frame
   logic          drop_q, drop_d;      // region full: discard until eof
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          bready_q, bready_d;
   logic          fdone_q, fdone_d;
   logic          eovf_q, eovf_d;
   logic          eresp_q, eresp_d;
   logic          ready_q, ready_d;

   logic accept, start, aw_pend, w_pend;
   logic unused_rd;

   assign accept  = db_valid && ready_q;
   assign start   = accept && db_sof && (state_q == IDLE || state_q == COLLECT);
   assign aw_pend = awvalid_q && !m_axi.awready;
   assign w_pend  = wvalid_q && !m_axi.wready;

   // Next-state and datapath: packing, write handshakes, response handling
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lane_d    = lane_q;
      data_d    = data_q;
      last_d    = last_q;
      drop_d    = drop_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      fdone_d   = 1'b0;
      eovf_d    = eovf_q;
      eresp_d   = eresp_q;
      if (start) begin
         // sof always (re)starts a frame; any partial word is thrown away
         idx_d   = '0;
         lane_d  = 3'd1;
         data_d  = {24'h0, db_data};
         eovf_d  = 1'b0;
         eresp_d = 1'b0;
         drop_d  = 1'b0;
         last_d  = db_eof;
         if (db_eof) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
         end else begin
            state_d = COLLECT;
         end
      end else begin
         case (state_q)
            IDLE: ;  // bytes without sof are dropped
            COLLECT: begin
               if (accept) begin
                  if (drop_q) begin
                     if (db_eof) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                        fdone_d = 1'b1;
                     end
                  end else begin
                     data_d[{lane_q[1:0], 3'b000} +: 8] = db_data;
                     lane_d = lane_q + 3'd1;
                     if (lane_q == 3'd3 || db_eof) begin
                        last_d = db_eof;
                        if (idx_q == IW'(DEPTH_WORDS)) begin
                           // region full: suppress the write
                           eovf_d = 1'b1;
                           lane_d = '0;
                           data_d = '0;
                           if (db_eof) begin
                              state_d = IDLE;
                              fdone_d = 1'b1;
                           end else begin
                              drop_d = 1'b1;
                           end
                        end else begin
                           state_d   = WRITE;
                           awvalid_d = 1'b1;
                           wvalid_d  = 1'b1;
                        end
                     end
                  end
               end
            end
            WRITE: begin
               // each valid drops on its own handshake
               awvalid_d = aw_pend;
               wvalid_d  = w_pend;
               if (!aw_pend && !w_pend) begin
                  state_d  = RESP;
                  bready_d = 1'b1;
               end
            end
            RESP: begin
               if (m_axi.bvalid) begin
                  bready_d = 1'b0;
                  idx_d    = idx_q + IW'(1);
                  lane_d   = '0;
                  data_d   = '0;
                  if (m_axi.bresp != 2'b00) eresp_d = 1'b1;
                  if (last_q) begin
                     state_d = IDLE;
                     fdone_d = 1'b1;
                  end else begin
                     state_d = COLLECT;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      ready_d = (state_d == IDLE) || (state_d == COLLECT);
   end

   // State register; reset drops every valid immediately
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         lane_q    <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         drop_q    <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         fdone_q   <= 1'b0;
         eovf_q    <= 1'b0;
         eresp_q   <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lane_q    <= lane_d;
         data_q    <= data_d;
         last_q    <= last_d;
         drop_q    <= drop_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         fdone_q   <= fdone_d;
         eovf_q    <= eovf_d;
         eresp_q   <= eresp_d;
         ready_q   <= ready_d;
      end
   end

   // Write strobe covers exactly the filled lanes
   always_comb begin
      case (lane_q)
         3'd1:    m_axi.wstrb = 4'b0001;
         3'd2:    m_axi.wstrb = 4'b0011;
         3'd3:    m_axi.wstrb = 4'b0111;
         default: m_axi.wstrb = 4'b1111;
      endcase
   end

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = BASE_ADDR + (32'(idx_q) << 2);
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = data_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = 1'b0;
   assign m_axi.araddr  = '0;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.rready  = 1'b0;
   assign unused_rd     = ^{m_axi.arready, m_axi.rvalid, m_axi.rdata, m_axi.rresp};

   assign db_ready     = ready_q;
   assign frame_done   = fdone_q;
   assign err_overflow = eovf_q;
   assign err_resp     = eresp_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_shared_data_writer.sv
// Directed bench: main DUT at BASE 0x1000 with controllable slave, second
// DUT with DEPTH_WORDS=2 behind an always-ready slave for overflow cases.
module tb_shared_data_writer;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   logic db_valid0 = 1'b0, db_valid1 = 1'b0;
   logic [7:0] db_data = 8'h0;
   logic db_sof = 1'b0, db_eof = 1'b0;
   logic db_ready0, db_ready1;
   logic frame_done0, frame_done1, err_ovf0, err_ovf1, err_resp0, err_resp1, busy0, busy1;
   logic tgt = 1'b0;

   int checks = 0;
   int errors = 0;
   int fd0 = 0, fd1 = 0, b0 = 0, w1 = 0;
   logic [31:0] aw_q[$];
   logic [31:0] wd_q[$];
   logic [3:0]  ws_q[$];

   axi4_lite_if axi0 ();
   axi4_lite_if axi1 ();

   shared_data_writer #(.BASE_ADDR(BASE), .DEPTH_WORDS(512)) u_dut (
      .clk(clk), .aresetn(aresetn), .db_valid(db_valid0), .db_data(db_data),
      .db_sof(db_sof), .db_eof(db_eof), .db_ready(db_ready0), .m_axi(axi0),
      .frame_done(frame_done0), .err_overflow(err_ovf0), .err_resp(err_resp0), .busy(busy0));

   shared_data_writer #(.BASE_ADDR(32'h0), .DEPTH_WORDS(2)) u_ovf (
      .clk(clk), .aresetn(aresetn), .db_valid(db_valid1), .db_data(db_data),
      .db_sof(db_sof), .db_eof(db_eof), .db_ready(db_ready1), .m_axi(axi1),
      .frame_done(frame_done1), .err_overflow(err_ovf1), .err_resp(err_resp1), .busy(busy1));

   always #5 clk = ~clk;

   // Bus monitors
   always @(posedge clk) begin
      if (axi0.awvalid && axi0.awready) aw_q.push_back(axi0.awaddr);
      if (axi0.wvalid && axi0.wready) begin
         wd_q.push_back(axi0.wdata);
         ws_q.push_back(axi0.wstrb);
      end
      if (axi0.bvalid && axi0.bready) b0++;
      if (frame_done0) fd0++;
      if (axi1.wvalid && axi1.wready) w1++;
      if (frame_done1) fd1++;
   end

   task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof);
      int n;
      n = 0;
      @(negedge clk);
      db_data = d; db_sof = sof; db_eof = eof;
      if (tgt) db_valid1 = 1'b1; else db_valid0 = 1'b1;
      while (((tgt ? db_ready1 : db_ready0) !== 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout: ready never rose for byte %h", d);
      end
      @(posedge clk);
      #1;
      db_valid0 = 1'b0; db_valid1 = 1'b0; db_sof = 1'b0; db_eof = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (((tgt ? busy1 : busy0) !== 1'b0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL wait_idle_timeout: busy still high");
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_mon();
      aw_q.delete(); wd_q.delete(); ws_q.delete();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({db_ready0, busy0, axi0.awvalid, axi0.wvalid, axi0.bready, frame_done0, err_ovf0, err_resp0} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b exp 00000000",
                  {db_ready0, busy0, axi0.awvalid, axi0.wvalid, axi0.bready, frame_done0, err_ovf0, err_resp0});
      end
      checks++;
      if ({axi0.arvalid, axi0.rready, axi0.awprot} !== 5'b0) begin
         errors++; $display("FAIL read_chan_idle: got %b exp 00000", {axi0.arvalid, axi0.rready, axi0.awprot});
      end
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      checks++;
      if (db_ready0 !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b exp 0", db_ready0); end
      @(posedge clk); #1;
      checks++;
      if (db_ready0 !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b exp 1", db_ready0); end
   endtask

   task automatic test_full_frame();
      int f;
      clear_mon(); f = fd0;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(i + 1), i == 0, i == 7);
         if (i == 3) begin
            checks++;
            if ({axi0.awvalid, axi0.wvalid} !== 2'b11) begin
               errors++; $display("FAIL write_latency: got %b exp 11", {axi0.awvalid, axi0.wvalid});
            end
         end
      end
      wait_idle();
      checks++;
      if (aw_q.size() != 2 || wd_q.size() != 2) begin
         errors++; $display("FAIL full_count: got aw=%0d w=%0d exp 2/2", aw_q.size(), wd_q.size());
      end else begin
         checks++;
         if ({aw_q[0], aw_q[1]} !== {BASE, BASE + 32'd4}) begin
            errors++; $display("FAIL full_addr: got %h %h exp %h %h", aw_q[0], aw_q[1], BASE, BASE + 32'd4);
         end
         checks++;
         if ({wd_q[0], wd_q[1], ws_q[0], ws_q[1]} !== {32'h04030201, 32'h08070605, 4'hF, 4'hF}) begin
            errors++; $display("FAIL full_data: got %h %h %h %h exp 04030201 08070605 f f", wd_q[0], wd_q[1], ws_q[0], ws_q[1]);
         end
      end
      checks++;
      if (fd0 - f != 1) begin errors++; $display("FAIL full_frame_done: got %0d exp 1", fd0 - f); end
   endtask

   task automatic test_partial();
      clear_mon();
      for (int i = 0; i < 6; i++) send_byte(8'(8'hAA + i), i == 0, i == 5);
      wait_idle();
      send_byte(8'h5A, 1'b1, 1'b1);
      wait_idle();
      checks++;
      if (wd_q.size() != 3) begin
         errors++; $display("FAIL partial_count: got %0d exp 3", wd_q.size());
      end else begin
         checks++;
         if ({wd_q[0], ws_q[0], wd_q[1], ws_q[1], aw_q[1]} !== {32'hADACABAA, 4'hF, 32'h0000AFAE, 4'h3, BASE + 32'd4}) begin
            errors++; $display("FAIL partial_word: got %h/%h %h/%h @%h exp adacabaa/f 0000afae/3 @%h",
                               wd_q[0], ws_q[0], wd_q[1], ws_q[1], aw_q[1], BASE + 32'd4);
         end
         checks++;
         if ({wd_q[2], ws_q[2], aw_q[2]} !== {32'h0000005A, 4'h1, BASE}) begin
            errors++; $display("FAIL single_byte: got %h/%h @%h exp 0000005a/1 @%h", wd_q[2], ws_q[2], aw_q[2], BASE);
         end
      end
   endtask

   task automatic test_aw_delay();
      clear_mon();
      axi0.awready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), i == 0, i == 3);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({axi0.awvalid, axi0.wvalid, db_ready0} !== 3'b100) begin
            errors++; $display("FAIL aw_delay_hold c%0d: got aw/w/rdy=%b exp 100", c, {axi0.awvalid, axi0.wvalid, db_ready0});
         end
      end
      axi0.awready = 1'b1;
      wait_idle();
      checks++;
      if (aw_q.size() != 1 || wd_q.size() != 1) begin
         errors++; $display("FAIL aw_delay_count: got aw=%0d w=%0d exp 1/1", aw_q.size(), wd_q.size());
      end else begin
         checks++;
         if ({aw_q[0], wd_q[0]} !== {BASE, 32'h14131211}) begin
            errors++; $display("FAIL aw_delay_data: got %h @%h exp 14131211 @%h", wd_q[0], aw_q[0], BASE);
         end
      end
   endtask

   task automatic test_bresp_err();
      int b, f, n;
      clear_mon(); f = fd0;
      axi0.bresp = 2'b10;
      for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), i == 0, 1'b0);
      b = b0; n = 0;
      while (b0 == b && n < 50) begin @(negedge clk); n++; end
      axi0.bresp = 2'b00;
      checks++;
      if (err_resp0 !== 1'b1) begin errors++; $display("FAIL err_resp_set: got %b exp 1", err_resp0); end
      for (int i = 4; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0, i == 7);
      wait_idle();
      checks++;
      if ({wd_q.size() == 2, err_resp0, fd0 - f == 1} !== 3'b111) begin
         errors++; $display("FAIL err_resp_frame: got writes=%0d err=%b fd=%0d exp 2 1 1", wd_q.size(), err_resp0, fd0 - f);
      end
   endtask

   task automatic test_abort();
      clear_mon();
      for (int i = 0; i < 3; i++) send_byte(8'(8'h21 + i), i == 0, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), i == 0, i == 7);
      wait_idle();
      checks++;
      if (wd_q.size() != 2) begin
         errors++; $display("FAIL abort_count: got %0d exp 2", wd_q.size());
      end else begin
         checks++;
         if ({aw_q[0], wd_q[0], wd_q[1]} !== {BASE, 32'h34333231, 32'h38373635}) begin
            errors++; $display("FAIL abort_data: got %h @%h %h exp 34333231 @%h 38373635", wd_q[0], aw_q[0], wd_q[1], BASE);
         end
      end
      checks++;
      if (err_resp0 !== 1'b0) begin errors++; $display("FAIL err_resp_cleared: got %b exp 0", err_resp0); end
   endtask

   task automatic test_overflow();
      int w, f;
      tgt = 1'b1;
      w = w1; f = fd1;
      for (int i = 0; i < 12; i++) begin
         send_byte(8'(8'h41 + i), i == 0, i == 11);
         if (i == 10) begin
            checks++;
            if ({fd1 == f, err_ovf1} !== 2'b10) begin
               errors++; $display("FAIL ovf_early: got fd=%0d ovf=%b exp 0 0", fd1 - f, err_ovf1);
            end
         end
      end
      checks++;
      if ({frame_done1, err_ovf1} !== 2'b11) begin
         errors++; $display("FAIL ovf_end: got done/ovf=%b exp 11", {frame_done1, err_ovf1});
      end
      wait_idle();
      checks++;
      if (w1 - w != 2) begin errors++; $display("FAIL ovf_writes: got %0d exp 2", w1 - w); end
      send_byte(8'h77, 1'b1, 1'b1);
      checks++;
      if (err_ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", err_ovf1); end
      wait_idle();
      // overflow mid-word: trailing bytes discarded until eof
      w = w1;
      for (int i = 0; i < 14; i++) begin
         send_byte(8'(i), i == 0, i == 13);
         if (i == 11) begin
            checks++;
            if ({err_ovf1, busy1, frame_done1} !== 3'b110) begin
               errors++; $display("FAIL ovf_drop: got ovf/busy/done=%b exp 110", {err_ovf1, busy1, frame_done1});
            end
         end
      end
      checks++;
      if (frame_done1 !== 1'b1) begin errors++; $display("FAIL ovf_drop_done: got %b exp 1", frame_done1); end
      wait_idle();
      checks++;
      if (w1 - w != 2) begin errors++; $display("FAIL ovf_drop_writes: got %0d exp 2", w1 - w); end
      tgt = 1'b0;
   endtask

   task automatic test_reset_mid();
      clear_mon();
      axi0.awready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), i == 0, 1'b0);
      @(negedge clk); #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if ({axi0.awvalid, axi0.wvalid, axi0.bready, busy0, db_ready0} !== 5'b0) begin
         errors++; $display("FAIL reset_mid: got %b exp 00000", {axi0.awvalid, axi0.wvalid, axi0.bready, busy0, db_ready0});
      end
      @(negedge clk);
      aresetn = 1'b1;
      axi0.awready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (aw_q.size() != 0) begin errors++; $display("FAIL reset_mid_lost: got %0d aw exp 0", aw_q.size()); end
      send_byte(8'h99, 1'b1, 1'b1);
      wait_idle();
      checks++;
      if (aw_q.size() != 1 || aw_q[0] !== BASE) begin
         errors++; $display("FAIL reset_mid_index: got n=%0d exp one write @%h", aw_q.size(), BASE);
      end
   endtask

   initial begin
      axi0.awready = 1'b1; axi0.wready = 1'b1; axi0.bvalid = 1'b1; axi0.bresp = 2'b00;
      axi0.arready = 1'b0; axi0.rvalid = 1'b0; axi0.rdata = '0; axi0.rresp = 2'b00;
      axi1.awready = 1'b1; axi1.wready = 1'b1; axi1.bvalid = 1'b1; axi1.bresp = 2'b00;
      axi1.arready = 1'b0; axi1.rvalid = 1'b0; axi1.rdata = '0; axi1.rresp = 2'b00;
      test_reset();
      test_full_frame();
      test_partial();
      test_aw_delay();
      test_bresp_err();
      test_abort();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/shared_data_writer.md
SHARED_DATA_WRITER -- requirements
Module: shared_data_writer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0 of the shared data region.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 512, region size in 32-bit words.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, named clk and aresetn.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 aresetn  input  1  asynchronous active-low reset.
REQ-006 db_valid  input  1  received data-buffer byte valid.
REQ-007 db_data  input  8  received data-buffer byte.
REQ-008 db_sof  input  1  qualifies db_valid; byte is first of a frame.
REQ-009 db_eof  input  1  qualifies db_valid; byte is last of a frame (sof and eof may both be set).
REQ-010 db_ready  output  1  byte accepted when db_valid and db_ready are both high.
REQ-011 m_axi  axi4_lite_if.m  32/32  AXI4-lite master; write channels only; arvalid=0, rready=0, awprot=3'b000.
REQ-012 frame_done  output  1  one-cycle pulse when a frame's final write response is received.
REQ-013 err_overflow  output  1  sticky; frame exceeded DEPTH_WORDS.
REQ-014 err_resp  output  1  sticky; a bresp other than OKAY was received.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Bytes SHALL be packed little-endian: byte n of a frame goes to lane n mod 4 of word n div 4.
REQ-017 The state machine SHALL have states IDLE, COLLECT, WRITE, RESP.
REQ-018 IDLE: db_ready=1; bytes without db_sof dropped; an accepted db_sof byte clears word index, lane count, err_overflow, err_resp, stores lane 0, enters COLLECT (or WRITE if db_eof).
REQ-019 COLLECT: db_ready=1; each accepted byte fills the next lane; on the 4th lane or db_eof, enter WRITE the next cycle.
REQ-020 WRITE: db_ready=0; awvalid and wvalid asserted in the same cycle; awaddr=BASE_ADDR+4*index; wstrb has one bit set per filled lane, unfilled lanes' wdata=0.
REQ-021 awvalid and wvalid SHALL each drop independently the cycle after their own handshake; once both handshakes are done, enter RESP.
REQ-022 RESP: bready=1; on bvalid, increment index modulo nothing (saturating check, REQ-024), set err_resp if bresp!=2'b00, then go to IDLE if the word closed the frame (pulse frame_done), else COLLECT.
REQ-023 Latency: a byte completing a word SHALL produce awvalid/wvalid exactly 1 cycle after acceptance.
REQ-024 If index == DEPTH_WORDS when a word would be written, the write SHALL be suppressed, err_overflow set, remaining bytes accepted and discarded until db_eof, then IDLE with frame_done pulsed.
REQ-025 An accepted db_sof byte in COLLECT SHALL abort the current frame: partial word discarded, no write, restart as in IDLE (REQ-018).
REQ-026 An error response SHALL NOT abort the frame; subsequent words SHALL still be written.
REQ-027 Outputs awvalid, wvalid, bready SHALL be registered; db_ready SHALL be a function of state only.

Reset
REQ-028 While aresetn=0: state IDLE, index 0, lane count 0, awvalid=wvalid=bready=0, frame_done=0, err_overflow=0, err_resp=0, busy=0, db_ready=0.
REQ-029 db_ready SHALL rise the first cycle after aresetn deasserts.
REQ-030 Reset asserted mid-transaction SHALL drop all valids immediately; the pending word is lost.

Verification
REQ-031 Frame 8 bytes 01..08, sof on first, eof on last, immediate ready/bvalid -> writes 0x04030201 @BASE, 0x08070605 @BASE+4, wstrb=4'hF, one frame_done.
REQ-032 Frame 6 bytes AA..AF -> second write data 0x0000AFAE, wstrb=4'h3 @BASE+4.
REQ-033 awready delayed 3 cycles after wready -> wvalid drops after its handshake, awvalid held, no duplicate write, db_ready low throughout.
REQ-034 DEPTH_WORDS=2, 12-byte frame -> exactly 2 writes, err_overflow=1, frame_done after byte 12; next sof clears err_overflow.
REQ-035 bresp=2'b10 on first word of 8-byte frame -> err_resp=1, second word still written, frame_done pulsed.
REQ-036 sof after 3 bytes of a frame -> no write of the partial word, new frame written starting @BASE.
